// File: rtl/alu_seq_core_if.sv
// Handshake/operand bundle for alu_seq_core; the flags member exists only when ALU_FLAGS_EN is defined.
// master = stimulus side, slave = the ALU core.
interface alu_seq_core_if #(
   parameter int unsigned WIDTH = 8
);
   logic             on;
   logic [2:0]       in_sel;
   logic [WIDTH-1:0] num1;
   logic [WIDTH-1:0] num2;
   logic [2:0]       op;
   logic             start;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   logic [1:0]       curr_state;
   logic [1:0]       next_state;
`ifdef ALU_FLAGS_EN
   logic [3:0]       flags;

   modport master (
      output on, in_sel, num1, num2, op, start,
      input  out, busy, done, curr_state, next_state, flags
   );
   modport slave (
      input  on, in_sel, num1, num2, op, start,
      output out, busy, done, curr_state, next_state, flags
   );
`else
   modport master (
      output on, in_sel, num1, num2, op, start,
      input  out, busy, done, curr_state, next_state
   );
   modport slave (
      input  on, in_sel, num1, num2, op, start,
      output out, busy, done, curr_state, next_state
   );
`endif
endinterface

// File: rtl/alu_seq_core.sv
// FSM-sequenced ALU: operand latches, single-cycle logic/arith ops, WIDTH-cycle shift-add multiplier.
// Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags output.
module alu_seq_core #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   alu_seq_core_if.slave bus
);
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned PW  = 2 * WIDTH;
   localparam int unsigned M   = WIDTH - 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      S_OFF  = 2'b00,
      S_IDLE = 2'b01,
      S_EXEC = 2'b10,
      S_DONE = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [2:0]       op_q, op_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [PW-1:0]    pp_c;
   logic [PW-1:0]    prod_c;
   logic [WIDTH-1:0] res_c;
   logic             shamt_big_c;
   logic             finish_c;

`ifdef ALU_FLAGS_EN
   logic [3:0] flags_q, flags_d;
   logic       carry_c;
   logic       ovf_c;
`endif

   // Result of the latched op on the latched operands; MUL reads the running partial product.
   always_comb begin
      shamt_big_c = 32'(b_q) >= WIDTH;
      pp_c        = b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0;
      prod_c      = acc_q + pp_c;
      res_c       = '0;
      case (op_q)
         OP_ADD:  res_c = a_q + b_q;
         OP_SUB:  res_c = a_q - b_q;
         OP_AND:  res_c = a_q & b_q;
         OP_OR:   res_c = a_q | b_q;
         OP_XOR:  res_c = a_q ^ b_q;
         OP_SHL:  res_c = shamt_big_c ? '0 : (a_q << b_q);
         OP_SHR:  res_c = shamt_big_c ? '0 : (a_q >> b_q);
         OP_MUL:  res_c = prod_c[WIDTH-1:0];
         default: res_c = '0;
      endcase
   end

`ifdef ALU_FLAGS_EN
   // Carry/borrow recovered from operand and result MSBs, so no extra adder is needed.
   always_comb begin
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      case (op_q)
         OP_ADD: begin
            carry_c = (a_q[M] & b_q[M]) | ((a_q[M] | b_q[M]) & ~res_c[M]);
            ovf_c   = (a_q[M] == b_q[M]) && (res_c[M] != a_q[M]);
         end
         OP_SUB: begin
            carry_c = (~a_q[M] & b_q[M]) | ((~a_q[M] | b_q[M]) & res_c[M]);
            ovf_c   = (a_q[M] != b_q[M]) && (res_c[M] != a_q[M]);
         end
         OP_SHL: begin
            for (int unsigned i = 1; i <= WIDTH; i++) begin
               if (32'(b_q) == i) carry_c = a_q[WIDTH-i];
            end
         end
         OP_MUL:  carry_c = |prod_c[PW-1:WIDTH];
         default: ;
      endcase
   end
`endif

   // Next-state and next-register values; power-off and reset override everything.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      out_d    = out_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      finish_c = (op_q != OP_MUL) || (cnt_q == SHW'(WIDTH - 1));
`ifdef ALU_FLAGS_EN
      flags_d  = flags_q;
`endif
      if (!bus.on) begin
         state_d = S_OFF;
         out_d   = '0;
         cnt_d   = '0;
`ifdef ALU_FLAGS_EN
         flags_d = '0;
`endif
      end else begin
         case (state_q)
            S_OFF: state_d = S_IDLE;
            S_IDLE: begin
               if (bus.in_sel[0]) begin
                  a_d = '0;
                  b_d = '0;
               end else if (bus.in_sel[1]) begin
                  a_d = bus.num1;
                  b_d = bus.num2;
               end
               if (bus.start) begin
                  op_d    = bus.op;
                  cnt_d   = '0;
                  acc_d   = '0;
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               acc_d = prod_c;
               cnt_d = cnt_q + SHW'(1);
               if (finish_c) begin
                  out_d   = res_c;
                  state_d = S_DONE;
`ifdef ALU_FLAGS_EN
                  flags_d = {res_c[M], res_c == '0, carry_c, ovf_c};
`endif
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (rst) state_d = S_OFF;
      busy_d = (state_d == S_EXEC);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_OFF;
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef ALU_FLAGS_EN
         flags_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef ALU_FLAGS_EN
         flags_q <= flags_d;
`endif
      end
   end

   assign bus.out        = out_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.curr_state = state_q;
   assign bus.next_state = state_d;
`ifdef ALU_FLAGS_EN
   assign bus.flags      = flags_q;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core (WIDTH=8): latency-counting result model checked every cycle plus directed literals.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_seq_core;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_seq_core_if #(.WIDTH(W)) bus ();
   alu_seq_core #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: state as 0..3, result computed whole at start, then released after a cycle count.
   int           ms;
   int           mwait;
   logic [W-1:0] ma, mb, mout, mpend;
   logic [3:0]   mflags, mpflags;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Returns {N,Z,C,V, result} from plain integer arithmetic.
   function automatic logic [W+3:0] ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int ia, ib, sa, sb, r, c, v;
      logic [W-1:0] res;
      ia = int'(a);
      ib = int'(b);
      sa = a[W-1] ? ia - (1 << W) : ia;
      sb = b[W-1] ? ib - (1 << W) : ib;
      c = 0;
      v = 0;
      case (o)
         3'd0: begin
            r = ia + ib;
            c = (r >= (1 << W)) ? 1 : 0;
            v = ((sa + sb) > (1 << (W-1)) - 1 || (sa + sb) < -(1 << (W-1))) ? 1 : 0;
         end
         3'd1: begin
            r = ia - ib;
            c = (ia < ib) ? 1 : 0;
            v = ((sa - sb) > (1 << (W-1)) - 1 || (sa - sb) < -(1 << (W-1))) ? 1 : 0;
         end
         3'd2: r = ia & ib;
         3'd3: r = ia | ib;
         3'd4: r = ia ^ ib;
         3'd5: begin
            r = (ib >= int'(W)) ? 0 : (ia << ib);
            c = (ib >= 1 && ib <= int'(W)) ? ((ia >> (int'(W) - ib)) & 1) : 0;
         end
         3'd6: r = (ib >= int'(W)) ? 0 : (ia >> ib);
         default: begin
            r = ia * ib;
            c = (r >= (1 << W)) ? 1 : 0;
         end
      endcase
      res = W'(r);
      return {res[W-1], res == '0, c[0], v[0], res};
   endfunction

   always @(posedge clk) begin : model
      logic [W+3:0] rr;
      if (rst) begin
         ms = 0; mwait = 0; ma = '0; mb = '0; mout = '0; mflags = '0;
      end else if (!bus.on) begin
         ms = 0; mwait = 0; mout = '0; mflags = '0;
      end else begin
         case (ms)
            0: ms = 1;
            1: begin
               if (bus.in_sel[0]) begin
                  ma = '0; mb = '0;
               end else if (bus.in_sel[1]) begin
                  ma = bus.num1; mb = bus.num2;
               end
               if (bus.start) begin
                  rr      = ref_op(bus.op, ma, mb);
                  mpend   = rr[W-1:0];
                  mpflags = rr[W+3:W];
                  mwait   = (bus.op == 3'd7) ? int'(W) : 1;
                  ms      = 2;
               end
            end
            2: begin
               mwait--;
               if (mwait == 0) begin
                  mout = mpend; mflags = mpflags; ms = 3;
               end
            end
            default: ms = 1;
         endcase
      end
   end

   always @(negedge clk) begin : compare
      int exp_ns;
      if (chk_en) begin
         if (rst || !bus.on)  exp_ns = 0;
         else if (ms == 0)    exp_ns = 1;
         else if (ms == 1)    exp_ns = bus.start ? 2 : 1;
         else if (ms == 2)    exp_ns = (mwait == 1) ? 3 : 2;
         else                 exp_ns = 1;
         chk("m_state", 32'(bus.curr_state), 32'(ms));
         chk("m_next_state", 32'(bus.next_state), 32'(exp_ns));
         chk("m_out", 32'(bus.out), 32'(mout));
         chk("m_busy", 32'(bus.busy), 32'(ms == 2));
         chk("m_done", 32'(bus.done), 32'(ms == 3));
`ifdef ALU_FLAGS_EN
         chk("m_flags", 32'(bus.flags), 32'(mflags));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from IDLE, wait (bounded) for done, return result and busy-cycle count, end in IDLE.
   task automatic run_op(input logic [2:0] o, input logic [2:0] sel, input logic [W-1:0] n1,
                         input logic [W-1:0] n2, output logic [W-1:0] res, output int busy_n);
      bit got;
      bus.in_sel = sel; bus.num1 = n1; bus.num2 = n2; bus.op = o; bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.in_sel = 3'b000;
      busy_n = 0;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         if (bus.busy) busy_n++;
         step();
      end
      chk("done_seen", 32'(got), 32'd1);
      res = bus.out;
      step();
   endtask

   initial begin
      logic [W-1:0] r;
      int bn, dn;
      rst = 1'b1;
      bus.on = 1'b0; bus.in_sel = 3'b000; bus.num1 = '0; bus.num2 = '0; bus.op = 3'd0; bus.start = 1'b0;
      step();
      chk_en = 1'b1;
      chk("rst_out", 32'(bus.out), 32'h0);
      chk("rst_state", 32'(bus.curr_state), 32'd0);
      chk("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
      rst = 1'b0;
      step();
      chk("off_hold", 32'(bus.curr_state), 32'd0);
      bus.on = 1'b1;
      step();
      chk("to_idle", 32'(bus.curr_state), 32'd1);

      // ADD with state trace
      bus.in_sel = 3'b010; bus.num1 = 8'h57; bus.num2 = 8'h1A; bus.op = 3'd0; bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.in_sel = 3'b000;
      chk("add_exec", 32'(bus.curr_state), 32'd2);
      step();
      chk("add_done_state", 32'(bus.curr_state), 32'd3);
      chk("add_done", 32'(bus.done), 32'd1);
      chk("add_out", 32'(bus.out), 32'h71);
      step();
      chk("add_idle", 32'(bus.curr_state), 32'd1);
      chk("add_done_pulse", 32'(bus.done), 32'd0);

      run_op(3'd1, 3'b010, 8'h00, 8'h01, r, bn);
      chk("sub_out", 32'(r), 32'hFF);
      chk("sub_busy_cycles", 32'(bn), 32'd1);
`ifdef ALU_FLAGS_EN
      chk("sub_flags", 32'(bus.flags), 32'b1010);
`endif
      run_op(3'd7, 3'b010, 8'h0F, 8'h11, r, bn);
      chk("mul_out", 32'(r), 32'hFF);
      chk("mul_busy_cycles", 32'(bn), 32'd8);
      run_op(3'd7, 3'b010, 8'h20, 8'h10, r, bn);
      chk("mul_wrap_out", 32'(r), 32'h00);
`ifdef ALU_FLAGS_EN
      chk("mul_wrap_flags", 32'(bus.flags), 32'b0110);
`endif
      run_op(3'd0, 3'b100, 8'hAA, 8'hAA, r, bn);
      chk("persist_add", 32'(r), 32'h30);
      run_op(3'd5, 3'b010, 8'h81, 8'h01, r, bn);
      chk("shl_out", 32'(r), 32'h02);
`ifdef ALU_FLAGS_EN
      chk("shl_flags", 32'(bus.flags), 32'b0010);
`endif
      run_op(3'd6, 3'b010, 8'h81, 8'h09, r, bn);
      chk("shr_big", 32'(r), 32'h00);
      run_op(3'd2, 3'b010, 8'hF0, 8'h3C, r, bn);
      chk("and_out", 32'(r), 32'h30);
      run_op(3'd3, 3'b000, 8'h00, 8'h00, r, bn);
      chk("or_out", 32'(r), 32'hFC);
      run_op(3'd4, 3'b000, 8'h00, 8'h00, r, bn);
      chk("xor_out", 32'(r), 32'hCC);

      // MUL aborted by power-off in its third EXEC cycle
      bus.in_sel = 3'b010; bus.num1 = 8'h0F; bus.num2 = 8'h11; bus.op = 3'd7; bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.in_sel = 3'b000;
      dn = 0;
      step(); dn += int'(bus.done);
      step(); dn += int'(bus.done);
      bus.on = 1'b0;
      step();
      chk("off_abort_state", 32'(bus.curr_state), 32'd0);
      chk("off_abort_out", 32'(bus.out), 32'h00);
      for (int i = 0; i < 4; i++) begin
         step(); dn += int'(bus.done);
      end
      chk("off_abort_no_done", 32'(dn), 32'd0);
      bus.on = 1'b1;
      step();
      chk("off_recover", 32'(bus.curr_state), 32'd1);

      // Same abort via reset
      run_op(3'd3, 3'b010, 8'hF0, 8'h3C, r, bn);
      chk("pre_rst_or", 32'(r), 32'hFC);
      bus.in_sel = 3'b010; bus.num1 = 8'h0F; bus.num2 = 8'h11; bus.op = 3'd7; bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.in_sel = 3'b000;
      step();
      step();
      rst = 1'b1;
      step();
      chk("rst_abort_state", 32'(bus.curr_state), 32'd0);
      chk("rst_abort_out", 32'(bus.out), 32'h00);
      chk("rst_abort_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      step();
      chk("rst_recover", 32'(bus.curr_state), 32'd1);
      run_op(3'd0, 3'b000, 8'h55, 8'h55, r, bn);
      chk("rst_cleared_ab", 32'(r), 32'h00);

      // Operand clear, then a start pulse during EXEC must not queue a second op
      run_op(3'd0, 3'b010, 8'h12, 8'h34, r, bn);
      chk("load_add", 32'(r), 32'h46);
      bus.in_sel = 3'b011;
      step();
      bus.in_sel = 3'b000; bus.op = 3'd0; bus.start = 1'b1;
      step();
      step();
      bus.start = 1'b0;
      dn = int'(bus.done);
      chk("clr_add_out", 32'(bus.out), 32'h00);
      for (int i = 0; i < 5; i++) begin
         step(); dn += int'(bus.done);
      end
      chk("single_done", 32'(dn), 32'd1);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
